// File: rtl/apb_protocol_monitor.sv
// Passive APB3/APB4 bus checker: tracks setup/access sequencing, stall stability,
// stall length and PSLVERR legality; reports sticky flags, first violation and counters.
//
// state     | meaning (describes the previous bus cycle)
// ST_IDLE   | no slave selected
// ST_SETUP  | setup cycle seen, access expected next
// ST_ACCESS | access cycle seen with PREADY low (stalled)
// ST_DONE   | access cycle completed with PREADY high
module apb_protocol_monitor #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int NS         = 4,
    parameter int MAXSTALL   = 16,
    parameter bit OPT_SLVERR = 1'b1,
    parameter bit OPT_APB4   = 1'b1,
    parameter int CW         = 16
) (
    input  logic            PCLK,
    input  logic            PRESET,
    input  logic [NS-1:0]   PSEL,
    input  logic            PENABLE,
    input  logic            PREADY,
    input  logic [AW-1:0]   PADDR,
    input  logic            PWRITE,
    input  logic [DW-1:0]   PWDATA,
    input  logic [DW/8-1:0] PWSTRB,
    input  logic [2:0]      PPROT,
    input  logic            PSLVERR,
    input  logic            i_clear,
    output logic [7:0]      o_viol,
    output logic            o_first_valid,
    output logic [2:0]      o_first_code,
    output logic [AW-1:0]   o_first_addr,
    output logic [CW-1:0]   o_xfer_count,
    output logic [CW-1:0]   o_err_count,
    output logic            o_irq
);

    localparam int SW  = (NS > 1) ? $clog2(NS) : 1;
    localparam int STW = (MAXSTALL > 0) ? $clog2(MAXSTALL + 1) : 1;
    localparam logic [STW-1:0] STALL_MAX  = STW'(MAXSTALL);
    localparam logic [STW-1:0] STALL_LAST = (MAXSTALL > 0) ? STW'(MAXSTALL - 1) : '0;
    localparam logic [NS-1:0]  SEL_ONE    = NS'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [STW-1:0]  stall_q, stall_d;
    logic [SW-1:0]   cap_sel_q;
    logic [AW-1:0]   cap_addr_q;
    logic            cap_write_q;
    logic [2:0]      cap_prot_q;
    logic [DW-1:0]   cap_wdata_q;
    logic [DW/8-1:0] cap_strb_q;
    logic [7:0]      viol_q, viol_d;
    logic            first_valid_q, first_valid_d;
    logic [2:0]      first_code_q, first_code_d;
    logic [AW-1:0]   first_addr_q, first_addr_d;
    logic [CW-1:0]   xfer_q, xfer_d, xfer_base;
    logic [CW-1:0]   err_q, err_d, err_base;

    logic [SW-1:0]   sel_idx;
    logic            sel_any, sel_multi, in_xfer;
    logic            setup_cyc, access_cyc, complete, mismatch, stall_hit;
    logic [7:0]      ev;
    logic [2:0]      ev_code;

    always_comb begin
        sel_idx = '0;
        for (int i = NS - 1; i >= 0; i--) begin
            if (PSEL[i]) sel_idx = SW'(i);
        end
    end

    assign sel_any    = |PSEL;
    assign sel_multi  = |(PSEL & (PSEL - SEL_ONE));
    assign in_xfer    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign setup_cyc  = sel_any && !in_xfer;
    assign access_cyc = sel_any && in_xfer;
    assign complete   = access_cyc && PREADY;

    // Write data and strobes only matter once the transfer is known to be a write.
    assign mismatch = (sel_idx != cap_sel_q) || (PADDR != cap_addr_q) ||
                      (PWRITE != cap_write_q) ||
                      (OPT_APB4 && (PPROT != cap_prot_q)) ||
                      (cap_write_q && ((PWDATA != cap_wdata_q) ||
                                       (OPT_APB4 && (PWSTRB != cap_strb_q))));

    always_comb begin
        stall_d   = '0;
        stall_hit = 1'b0;
        if (access_cyc && !PREADY) begin
            stall_d   = (stall_q != STALL_MAX) ? stall_q + STW'(1) : stall_q;
            stall_hit = (MAXSTALL != 0) && (stall_q == STALL_LAST);
        end
    end

    always_comb begin
        ev    = '0;
        ev[0] = sel_multi;
        ev[1] = !sel_any && in_xfer;
        ev[2] = setup_cyc && PENABLE;
        ev[3] = access_cyc && (state_q == ST_SETUP) && !PENABLE;
        ev[4] = access_cyc && (state_q == ST_ACCESS) && !PENABLE;
        ev[5] = access_cyc && mismatch;
        ev[6] = stall_hit;
        ev[7] = OPT_SLVERR ? (PSLVERR && !complete) : PSLVERR;
        ev_code = '0;
        for (int b = 7; b >= 0; b--) begin
            if (ev[b]) ev_code = 3'(b);
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        if (setup_cyc)       state_d = ST_SETUP;
        else if (access_cyc) state_d = PREADY ? ST_DONE : ST_ACCESS;
    end

    // A violation coincident with i_clear is recorded on top of the cleared state.
    always_comb begin
        viol_d        = (i_clear ? 8'h00 : viol_q) | ev;
        first_valid_d = i_clear ? 1'b0 : first_valid_q;
        first_code_d  = i_clear ? 3'd0 : first_code_q;
        first_addr_d  = i_clear ? '0 : first_addr_q;
        if (!first_valid_d && (ev != 8'h00)) begin
            first_valid_d = 1'b1;
            first_code_d  = ev_code;
            first_addr_d  = PADDR;
        end
        xfer_base = i_clear ? '0 : xfer_q;
        err_base  = i_clear ? '0 : err_q;
        xfer_d    = xfer_base;
        err_d     = err_base;
        if (complete && (xfer_base != '1)) xfer_d = xfer_base + CW'(1);
        if (complete && PSLVERR && (err_base != '1)) err_d = err_base + CW'(1);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= ST_IDLE;
            stall_q       <= '0;
            cap_sel_q     <= '0;
            cap_addr_q    <= '0;
            cap_write_q   <= 1'b0;
            cap_prot_q    <= '0;
            cap_wdata_q   <= '0;
            cap_strb_q    <= '0;
            viol_q        <= '0;
            first_valid_q <= 1'b0;
            first_code_q  <= '0;
            first_addr_q  <= '0;
            xfer_q        <= '0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            stall_q       <= stall_d;
            viol_q        <= viol_d;
            first_valid_q <= first_valid_d;
            first_code_q  <= first_code_d;
            first_addr_q  <= first_addr_d;
            xfer_q        <= xfer_d;
            err_q         <= err_d;
            if (setup_cyc) begin
                cap_sel_q   <= sel_idx;
                cap_addr_q  <= PADDR;
                cap_write_q <= PWRITE;
                cap_prot_q  <= PPROT;
                cap_wdata_q <= PWDATA;
                cap_strb_q  <= PWSTRB;
            end
        end
    end

    assign o_viol        = viol_q;
    assign o_first_valid = first_valid_q;
    assign o_first_code  = first_code_q;
    assign o_first_addr  = first_addr_q;
    assign o_xfer_count  = xfer_q;
    assign o_err_count   = err_q;
    assign o_irq         = |viol_q;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// Bench for apb_protocol_monitor: directed vector table for the documented scenarios,
// then randomized bus traffic checked against a rule-level reference model.
module tb_apb_protocol_monitor;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int NS       = 4;
    localparam int MAXSTALL = 4;
    localparam int CW       = 4;
    localparam int CMAX     = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          PRESET, PENABLE, PREADY, PWRITE, PSLVERR, i_clear;
    logic [NS-1:0] PSEL;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [3:0]    PWSTRB;
    logic [2:0]    PPROT;
    logic [7:0]    o_viol;
    logic          o_first_valid, o_irq;
    logic [2:0]    o_first_code;
    logic [AW-1:0] o_first_addr;
    logic [CW-1:0] o_xfer_count, o_err_count;

    always #5 clk = ~clk;

    apb_protocol_monitor #(
        .AW(AW), .DW(DW), .NS(NS), .MAXSTALL(MAXSTALL),
        .OPT_SLVERR(1'b1), .OPT_APB4(1'b1), .CW(CW)
    ) dut (
        .PCLK(clk), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PREADY(PREADY),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PWSTRB(PWSTRB), .PPROT(PPROT),
        .PSLVERR(PSLVERR), .i_clear(i_clear), .o_viol(o_viol), .o_first_valid(o_first_valid),
        .o_first_code(o_first_code), .o_first_addr(o_first_addr),
        .o_xfer_count(o_xfer_count), .o_err_count(o_err_count), .o_irq(o_irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, clr;
        logic [3:0]  psel;
        logic        pen, rdy, wr, err;
        logic [31:0] addr;
        logic [7:0]  e_viol;
        logic        e_fv;
        logic [2:0]  e_code;
        logic [31:0] e_faddr;
        int          e_xfer, e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic clr, input logic [3:0] psel,
                                input logic pen, input logic rdy, input logic wr,
                                input logic err, input logic [31:0] addr,
                                input logic [7:0] ev, input logic fv, input logic [2:0] code,
                                input logic [31:0] fa, input int x, input int e);
        vec_t v;
        v.rst = rst; v.clr = clr; v.psel = psel; v.pen = pen; v.rdy = rdy; v.wr = wr;
        v.err = err; v.addr = addr; v.e_viol = ev; v.e_fv = fv; v.e_code = code;
        v.e_faddr = fa; v.e_xfer = x; v.e_err = e;
        return v;
    endfunction

    // Reference model: phase flags, a plain stall tally and a record of the setup beat.
    bit          m_exp_acc, m_prev_setup;
    int          m_stalls, m_code, m_xfer, m_err, c_sel;
    bit          m_fv;
    logic [7:0]  m_viol;
    logic [31:0] m_faddr, c_addr, c_wdata;
    logic        c_wr;
    logic [2:0]  c_prot;
    logic [3:0]  c_strb;

    task automatic model_reset();
        m_exp_acc = 0; m_prev_setup = 0; m_stalls = 0; m_code = 0; m_xfer = 0; m_err = 0;
        m_fv = 0; m_viol = 8'h00; m_faddr = '0;
        c_sel = 0; c_addr = '0; c_wdata = '0; c_wr = 1'b0; c_prot = '0; c_strb = '0;
    endtask

    task automatic model_step();
        int         nsel, idx;
        bit         acc, stp;
        logic [7:0] ev;
        if (PRESET) begin
            model_reset();
            return;
        end
        nsel = $countones(PSEL);
        idx  = -1;
        for (int i = NS - 1; i >= 0; i--) if (PSEL[i]) idx = i;
        acc = (nsel > 0) && m_exp_acc;
        stp = (nsel > 0) && !m_exp_acc;
        ev  = 8'h00;
        ev[0] = (nsel > 1);
        ev[1] = (nsel == 0) && m_exp_acc;
        ev[2] = stp && PENABLE;
        ev[3] = acc && m_prev_setup && !PENABLE;
        ev[4] = acc && !m_prev_setup && !PENABLE;
        if (acc)
            ev[5] = (idx != c_sel) || (PADDR != c_addr) || (PWRITE != c_wr) ||
                    (PPROT != c_prot) || (c_wr && ((PWDATA != c_wdata) || (PWSTRB != c_strb)));
        if (acc && !PREADY) begin
            m_stalls++;
            ev[6] = (m_stalls == MAXSTALL);
        end else begin
            m_stalls = 0;
        end
        ev[7] = PSLVERR && !(acc && PREADY);
        if (i_clear) begin
            m_viol = 8'h00; m_fv = 0; m_code = 0; m_faddr = '0; m_xfer = 0; m_err = 0;
        end
        m_viol = m_viol | ev;
        if (!m_fv && (ev != 8'h00)) begin
            m_fv = 1;
            for (int b = 7; b >= 0; b--) if (ev[b]) m_code = b;
            m_faddr = PADDR;
        end
        if (acc && PREADY) begin
            if (m_xfer < CMAX) m_xfer++;
            if (PSLVERR && (m_err < CMAX)) m_err++;
        end
        if (stp) begin
            c_sel = idx; c_addr = PADDR; c_wr = PWRITE; c_prot = PPROT;
            c_wdata = PWDATA; c_strb = PWSTRB;
        end
        m_exp_acc    = acc ? !PREADY : stp;
        m_prev_setup = stp;
    endtask

    task automatic drive_cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic compare_model();
        chk("viol",   32'(o_viol),        32'(m_viol));
        chk("fvalid", 32'(o_first_valid), 32'(m_fv));
        chk("fcode",  32'(o_first_code),  32'(m_code));
        chk("faddr",  o_first_addr,       m_faddr);
        chk("xfer",   32'(o_xfer_count),  32'(m_xfer));
        chk("errcnt", 32'(o_err_count),   32'(m_err));
        chk("irq",    32'(o_irq),         32'(m_viol != 8'h00));
    endtask

    bit         g_busy;
    int         g_left, r;
    logic [3:0] g_sel;

    initial begin
        PRESET = 1'b1; i_clear = 1'b0; PSEL = '0; PENABLE = 1'b0; PREADY = 1'b0;
        PADDR = '0; PWRITE = 1'b0; PWDATA = '0; PWSTRB = 4'hF; PPROT = '0; PSLVERR = 1'b0;
        model_reset();

        //          rst clr psel pen rdy wr  err addr       viol  fv code faddr    xf er
        vecs.push_back(mk(1, 0, 4'h0, 0, 0, 0, 0, 32'h000, 8'h00, 0, 0, 32'h000, 0, 0));
        vecs.push_back(mk(0, 0, 4'h1, 0, 0, 1, 0, 32'h100, 8'h00, 0, 0, 32'h000, 0, 0));
        vecs.push_back(mk(0, 0, 4'h1, 1, 1, 1, 0, 32'h100, 8'h00, 0, 0, 32'h000, 1, 0));
        vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 0, 32'h000, 8'h00, 0, 0, 32'h000, 1, 0));
        vecs.push_back(mk(0, 0, 4'h1, 0, 0, 0, 0, 32'h200, 8'h00, 0, 0, 32'h000, 1, 0));
        vecs.push_back(mk(0, 0, 4'h1, 1, 0, 0, 1, 32'h200, 8'h80, 1, 7, 32'h200, 1, 0));
        vecs.push_back(mk(0, 0, 4'h1, 1, 1, 0, 1, 32'h200, 8'h80, 1, 7, 32'h200, 2, 1));
        vecs.push_back(mk(0, 1, 4'h0, 0, 0, 0, 0, 32'h000, 8'h00, 0, 0, 32'h000, 0, 0));
        vecs.push_back(mk(0, 0, 4'h1, 0, 0, 1, 0, 32'h300, 8'h00, 0, 0, 32'h000, 0, 0));
        vecs.push_back(mk(0, 1, 4'h1, 0, 0, 1, 0, 32'h300, 8'h08, 1, 3, 32'h300, 0, 0));
        vecs.push_back(mk(0, 0, 4'h1, 1, 1, 1, 0, 32'h300, 8'h08, 1, 3, 32'h300, 1, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 0, 0, 0, 32'h000, 8'h00, 0, 0, 32'h000, 0, 0));
        vecs.push_back(mk(0, 0, 4'h1, 1, 0, 0, 0, 32'h400, 8'h04, 1, 2, 32'h400, 0, 0));
        vecs.push_back(mk(0, 0, 4'h1, 1, 0, 0, 0, 32'h400, 8'h04, 1, 2, 32'h400, 0, 0));
        vecs.push_back(mk(0, 0, 4'h0, 0, 0, 0, 0, 32'h000, 8'h06, 1, 2, 32'h400, 0, 0));
        vecs.push_back(mk(0, 1, 4'h0, 0, 0, 0, 0, 32'h000, 8'h00, 0, 0, 32'h000, 0, 0));
        vecs.push_back(mk(0, 0, 4'h1, 0, 0, 1, 0, 32'h100, 8'h00, 0, 0, 32'h000, 0, 0));
        vecs.push_back(mk(0, 0, 4'h1, 1, 0, 1, 0, 32'h100, 8'h00, 0, 0, 32'h000, 0, 0));
        vecs.push_back(mk(0, 0, 4'h1, 1, 0, 1, 0, 32'h104, 8'h20, 1, 5, 32'h104, 0, 0));
        vecs.push_back(mk(0, 0, 4'h1, 1, 1, 1, 0, 32'h100, 8'h20, 1, 5, 32'h104, 1, 0));
        vecs.push_back(mk(0, 1, 4'h0, 0, 0, 0, 0, 32'h000, 8'h00, 0, 0, 32'h000, 0, 0));
        vecs.push_back(mk(0, 0, 4'h1, 0, 0, 1, 0, 32'h100, 8'h00, 0, 0, 32'h000, 0, 0));
        vecs.push_back(mk(0, 0, 4'h3, 1, 0, 1, 0, 32'h104, 8'h21, 1, 0, 32'h104, 0, 0));
        vecs.push_back(mk(0, 0, 4'h1, 1, 1, 1, 0, 32'h100, 8'h21, 1, 0, 32'h104, 1, 0));
        vecs.push_back(mk(0, 1, 4'h0, 0, 0, 0, 0, 32'h000, 8'h00, 0, 0, 32'h000, 0, 0));
        vecs.push_back(mk(0, 0, 4'h2, 0, 0, 0, 0, 32'h500, 8'h00, 0, 0, 32'h000, 0, 0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 0, 4'h2, 1, 0, 0, 0, 32'h500, 8'h00, 0, 0, 32'h000, 0, 0));
        vecs.push_back(mk(0, 0, 4'h2, 1, 0, 0, 0, 32'h500, 8'h40, 1, 6, 32'h500, 0, 0));
        vecs.push_back(mk(0, 0, 4'h2, 1, 0, 0, 0, 32'h500, 8'h40, 1, 6, 32'h500, 0, 0));
        vecs.push_back(mk(0, 0, 4'h2, 1, 1, 0, 0, 32'h500, 8'h40, 1, 6, 32'h500, 1, 0));
        vecs.push_back(mk(0, 0, 4'h2, 0, 0, 0, 0, 32'h504, 8'h40, 1, 6, 32'h500, 1, 0));
        vecs.push_back(mk(0, 0, 4'h2, 1, 1, 0, 0, 32'h504, 8'h40, 1, 6, 32'h500, 2, 0));
        vecs.push_back(mk(0, 0, 4'h1, 0, 0, 0, 0, 32'h600, 8'h40, 1, 6, 32'h500, 2, 0));
        vecs.push_back(mk(0, 0, 4'h1, 1, 0, 0, 0, 32'h600, 8'h40, 1, 6, 32'h500, 2, 0));
        vecs.push_back(mk(1, 0, 4'h1, 1, 0, 0, 0, 32'h600, 8'h00, 0, 0, 32'h000, 0, 0));
        vecs.push_back(mk(0, 0, 4'h1, 1, 1, 0, 0, 32'h600, 8'h04, 1, 2, 32'h600, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 0, 0, 0, 0, 32'h000, 8'h00, 0, 0, 32'h000, 0, 0));

        @(negedge clk);
        foreach (vecs[i]) begin
            PRESET = vecs[i].rst; i_clear = vecs[i].clr; PSEL = vecs[i].psel;
            PENABLE = vecs[i].pen; PREADY = vecs[i].rdy; PWRITE = vecs[i].wr;
            PSLVERR = vecs[i].err; PADDR = vecs[i].addr;
            PWDATA = '0; PWSTRB = 4'hF; PPROT = '0;
            drive_cycle();
            chk($sformatf("tbl%0d_viol", i),   32'(o_viol),        32'(vecs[i].e_viol));
            chk($sformatf("tbl%0d_fvalid", i), 32'(o_first_valid), 32'(vecs[i].e_fv));
            chk($sformatf("tbl%0d_fcode", i),  32'(o_first_code),  32'(vecs[i].e_code));
            chk($sformatf("tbl%0d_faddr", i),  o_first_addr,       vecs[i].e_faddr);
            chk($sformatf("tbl%0d_xfer", i),   32'(o_xfer_count),  32'(vecs[i].e_xfer));
            chk($sformatf("tbl%0d_err", i),    32'(o_err_count),   32'(vecs[i].e_err));
            chk($sformatf("tbl%0d_irq", i),    32'(o_irq),         32'(vecs[i].e_viol != 8'h00));
        end

        PRESET = 1'b1; i_clear = 1'b0; PSEL = '0; PENABLE = 1'b0; PSLVERR = 1'b0;
        drive_cycle();
        g_busy = 0; g_left = 0; g_sel = 4'h1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            PRESET  = ($urandom_range(0, 199) == 0);
            i_clear = ($urandom_range(0, 149) == 0);
            PSLVERR = ($urandom_range(0, 9) == 0);
            if (!g_busy) begin
                if ($urandom_range(0, 9) < 6) begin
                    g_sel   = 4'(1 << $urandom_range(0, 3));
                    PSEL    = g_sel;
                    PENABLE = ($urandom_range(0, 19) == 0);
                    PADDR   = 32'($urandom_range(0, 255)) << 2;
                    PWRITE  = 1'($urandom);
                    PWDATA  = $urandom;
                    PWSTRB  = 4'($urandom);
                    PPROT   = 3'($urandom);
                    PREADY  = 1'($urandom);
                    g_busy  = 1;
                    g_left  = $urandom_range(0, 6);
                end else begin
                    PSEL = '0; PENABLE = 1'b0; PREADY = 1'($urandom);
                end
            end else begin
                r    = $urandom_range(0, 99);
                PSEL = g_sel;
                if (r < 3)      PSEL = '0;
                else if (r < 6) PSEL = g_sel | 4'($urandom);
                PENABLE = ($urandom_range(0, 19) != 0);
                if ($urandom_range(0, 29) == 0) PADDR  = PADDR ^ 32'h4;
                if ($urandom_range(0, 29) == 0) PWDATA = PWDATA ^ 32'h1;
                if ($urandom_range(0, 39) == 0) PWSTRB = PWSTRB ^ 4'h1;
                if ($urandom_range(0, 39) == 0) PPROT  = PPROT ^ 3'h1;
                PREADY = (g_left == 0);
                if (g_left > 0) g_left--;
                if (PREADY || (PSEL == '0)) g_busy = 0;
            end
            if (PRESET) g_busy = 0;
            drive_cycle();
            compare_model();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
